// File: rtl/halt_state_checker.sv
// ---------------------------------------------------------------------------
// halt_state_checker
//
// End-of-program checker placed after a single-cycle CPU. It waits for the
// halt instruction word, freezes the CPU and then sweeps the architectural
// state one entry per clock: the PC, every data-memory word and every
// register. Each entry is compared against an expected-value ROM. It reports
// a verdict, a mismatch count and the ROM index of the first mismatch.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-low reset
//   instr_i      instruction currently fetched by the CPU
//   pc_i         current PC value
//   mem_addr_o   data-memory word index to read (read data returns same cycle)
//   mem_data_i   data-memory read data
//   reg_addr_o   register-file read index (read data returns same cycle)
//   reg_data_i   register-file read data
//   exp_addr_o   expected-ROM index (0 = PC, 1.. = memory, then registers)
//   exp_data_i   expected-ROM read data
//   stall_o      freezes the CPU from the cycle after the halt onwards
//   done_o       sweep finished; sticky until reset
//   pass_o       done_o and no mismatches
//   err_cnt_o    number of mismatching entries (saturating)
//   first_err_o  ROM index of the first mismatch, all-ones if none
// ---------------------------------------------------------------------------
module halt_state_checker #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          MEM_WORDS = 32,
    parameter int          REG_COUNT = 32,
    parameter int          IDX_W     = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    output logic [4:0]       mem_addr_o,
    input  logic [31:0]      mem_data_i,
    output logic [4:0]       reg_addr_o,
    input  logic [31:0]      reg_data_i,
    output logic [IDX_W-1:0] exp_addr_o,
    input  logic [31:0]      exp_data_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [IDX_W-1:0] err_cnt_o,
    output logic [IDX_W-1:0] first_err_o
);

    localparam logic [IDX_W-1:0] NO_ERR   = '1;
    localparam logic [4:0]       MEM_LAST = 5'(MEM_WORDS - 1);
    localparam logic [4:0]       REG_LAST = 5'(REG_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CHK_PC  = 3'd2,
        CHK_MEM = 3'd3,
        CHK_REG = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_reg, state_next;
    logic [4:0]       idx_reg, idx_next;
    logic             stall_reg, done_reg;
    logic [IDX_W-1:0] err_reg, err_next;
    logic [IDX_W-1:0] first_reg, first_next;

    logic             cmp_en;
    logic [31:0]      cmp_val;
    logic             mismatch;

    // Next-state, read addresses and the value under comparison this cycle.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mem_addr_o = '0;
        reg_addr_o = '0;
        exp_addr_o = '0;
        cmp_en     = 1'b0;
        cmp_val    = '0;
        case (state_reg)
            IDLE: begin
                // An X on instr_i does not satisfy the if, so it never triggers.
                if (instr_i == HALT_WORD) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                // One settling cycle so the PC of the halt instruction is final.
                state_next = CHK_PC;
            end
            CHK_PC: begin
                exp_addr_o = '0;
                cmp_en     = 1'b1;
                cmp_val    = pc_i;
                idx_next   = '0;
                state_next = CHK_MEM;
            end
            CHK_MEM: begin
                mem_addr_o = idx_reg;
                exp_addr_o = IDX_W'(1) + IDX_W'(idx_reg);
                cmp_en     = 1'b1;
                cmp_val    = mem_data_i;
                if (idx_reg == MEM_LAST) begin
                    idx_next   = '0;
                    state_next = CHK_REG;
                end else begin
                    idx_next = idx_reg + 5'd1;
                end
            end
            CHK_REG: begin
                reg_addr_o = idx_reg;
                exp_addr_o = IDX_W'(1 + MEM_WORDS) + IDX_W'(idx_reg);
                cmp_en     = 1'b1;
                cmp_val    = reg_data_i;
                if (idx_reg == REG_LAST) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 5'd1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign mismatch = cmp_en && (cmp_val != exp_data_i);

    always_comb begin
        err_next   = err_reg;
        first_next = first_reg;
        if (mismatch) begin
            if (err_reg != NO_ERR) begin
                err_next = err_reg + IDX_W'(1);
            end
            // Only the earliest mismatch is recorded.
            if (first_reg == NO_ERR) begin
                first_next = exp_addr_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            stall_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= '0;
            first_reg <= NO_ERR;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            stall_reg <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
            err_reg   <= err_next;
            first_reg <= first_next;
        end
    end

    assign stall_o     = stall_reg;
    assign done_o      = done_reg;
    assign pass_o      = done_reg && (err_reg == '0);
    assign err_cnt_o   = err_reg;
    assign first_err_o = first_reg;

endmodule

// File: tb/tb_halt_state_checker.sv
module tb_halt_state_checker;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int NENT = 65;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [6:0]  exp_addr_o;
    logic [31:0] exp_data_i;
    logic        stall_o, done_o, pass_o;
    logic [6:0]  err_cnt_o, first_err_o;

    // CPU and ROM models: combinational reads, like the real memories.
    logic [31:0] dmem [32];
    logic [31:0] rf   [32];
    logic [31:0] rom  [NENT];

    assign mem_data_i = dmem[mem_addr_o];
    assign reg_data_i = rf[reg_addr_o];
    assign exp_data_i = (exp_addr_o < 7'(NENT)) ? rom[exp_addr_o] : 32'h0;

    always #5 clk_i = ~clk_i;

    halt_state_checker dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
        .exp_addr_o(exp_addr_o), .exp_data_i(exp_data_i),
        .stall_o(stall_o), .done_o(done_o), .pass_o(pass_o),
        .err_cnt_o(err_cnt_o), .first_err_o(first_err_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        string name;
        bit    pc_bad;
        int    mem_bad;   // -1 = none
        int    reg_bad;   // -1 = none
        int    exp_err;
        int    exp_first;
        bit    exp_pass;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] nonhalt();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0;
        return v;
    endfunction

    // Value that the sweep sees for ROM entry i.
    function automatic logic [31:0] state_entry(input int i);
        if (i == 0) return pc_i;
        if (i <= 32) return dmem[i-1];
        return rf[i-33];
    endfunction

    // Reference verdict: count differing entries, lowest differing index.
    task automatic model(output int err, output int first);
        err = 0;
        first = 127;
        for (int i = 0; i < NENT; i++) begin
            if (state_entry(i) != rom[i]) begin
                if (first == 127) first = i;
                err++;
            end
        end
    endtask

    task automatic fill_matching();
        pc_i = $urandom;
        for (int i = 0; i < 32; i++) begin
            dmem[i] = $urandom;
            rf[i]   = $urandom;
        end
        for (int i = 0; i < NENT; i++) rom[i] = state_entry(i);
    endtask

    task automatic corrupt(input int i);
        rom[i] = rom[i] ^ (32'h1 << $urandom_range(0, 31));
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        instr_i = $urandom;
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_first", first_err_o, 7'h7F);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_hold_stall", stall_o, 0);
        @(negedge clk_i);
        instr_i = nonhalt();
        rst_i = 1'b1;
    endtask

    task automatic run_sweep(input string name, input int exp_err, input int exp_first, input bit exp_pass);
        int n;
        bit seen;
        bit stall_drop;
        @(negedge clk_i);
        instr_i = nonhalt();
        repeat ($urandom_range(2, 6)) @(negedge clk_i);
        check({name, "_prehalt_stall"}, stall_o, 0);
        instr_i = HALT;
        @(posedge clk_i);
        #1;
        check({name, "_stall_after_halt"}, stall_o, 1);
        instr_i = nonhalt();
        n = 0;
        seen = 0;
        stall_drop = 0;
        while (n < 200 && !seen) begin
            @(posedge clk_i);
            #1;
            n++;
            if (!stall_o) stall_drop = 1;
            if (done_o) seen = 1;
        end
        check({name, "_latency"}, n, 66);
        check({name, "_stall_held"}, stall_drop, 0);
        check({name, "_err"}, err_cnt_o, exp_err);
        check({name, "_first"}, first_err_o, exp_first);
        check({name, "_pass"}, pass_o, exp_pass);
        $display("[TB] sweep %s: err=%0d first=%0d pass=%0b latency=%0d", name, err_cnt_o, first_err_o, pass_o, n);
    endtask

    initial begin
        int e, f;
        bit stalled;
        logic [6:0] err_save, first_save;

        vecs[0] = '{"all_match",   1'b0, -1, -1, 0, 127, 1'b1};
        vecs[1] = '{"mem5",        1'b0,  5, -1, 1,   6, 1'b0};
        vecs[2] = '{"pc_reg31",    1'b1, -1, 31, 2,   0, 1'b0};
        vecs[3] = '{"reg0",        1'b0, -1,  0, 1,  33, 1'b0};
        vecs[4] = '{"mem31_reg0",  1'b0, 31,  0, 2,  32, 1'b0};
        vecs[5] = '{"mem0",        1'b0,  0, -1, 1,   1, 1'b0};

        fill_matching();
        for (int t = 0; t < 6; t++) begin
            fill_matching();
            if (vecs[t].pc_bad) begin
                pc_i = 32'h0000_0040;
                rom[0] = 32'h0000_003C;
            end
            if (vecs[t].mem_bad == 5) begin
                dmem[5] = 32'h0000_0007;
                rom[6]  = 32'h0000_0008;
            end else if (vecs[t].mem_bad >= 0) begin
                corrupt(1 + vecs[t].mem_bad);
            end
            if (vecs[t].reg_bad >= 0) corrupt(33 + vecs[t].reg_bad);
            apply_reset();
            run_sweep(vecs[t].name, vecs[t].exp_err, vecs[t].exp_first, vecs[t].exp_pass);
        end

        // Randomized state and mismatch patterns against the reference model.
        for (int r = 0; r < 8; r++) begin
            fill_matching();
            for (int i = 0; i < NENT; i++) begin
                if (r == 7 || $urandom_range(0, 7) == 0) corrupt(i);
            end
            model(e, f);
            apply_reset();
            run_sweep($sformatf("rand%0d", r), e, f, e == 0);
        end

        // Reset in the middle of the memory sweep, then a full re-run.
        fill_matching();
        pc_i = 32'h0000_0040;
        rom[0] = 32'h0000_003C;
        apply_reset();
        @(negedge clk_i);
        instr_i = HALT;
        @(posedge clk_i);
        #1;
        instr_i = nonhalt();
        repeat (12) @(posedge clk_i);
        #1;
        check("mid_mem_addr", mem_addr_o, 10);
        check("mid_err_before_rst", err_cnt_o, 1);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_stall", stall_o, 0);
        check("mid_rst_err", err_cnt_o, 0);
        check("mid_rst_first", first_err_o, 7'h7F);
        check("mid_rst_done", done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        model(e, f);
        run_sweep("after_abort", e, f, e == 0);

        // Near-halt words never trigger; halts after DONE change nothing.
        fill_matching();
        corrupt(40);
        apply_reset();
        stalled = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            instr_i = (c < 100) ? 32'hFFFF_FFFE : ~(32'h1 << $urandom_range(0, 31));
            if (stall_o) stalled = 1;
        end
        @(negedge clk_i);
        if (stall_o) stalled = 1;
        check("nearhalt_no_trigger", stalled, 0);
        run_sweep("after_nearhalt", 1, 40, 1'b0);
        err_save = err_cnt_o;
        first_save = first_err_o;
        corrupt(3);
        @(negedge clk_i);
        instr_i = HALT;
        repeat (80) @(negedge clk_i);
        check("post_done_err", err_cnt_o, err_save);
        check("post_done_first", first_err_o, first_save);
        check("post_done_done", done_o, 1);
        check("post_done_stall", stall_o, 1);
        $display("[TB] post-done halts: err=%0d first=%0d done=%0b", err_cnt_o, first_err_o, done_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
